// File: rtl/preg_freelist.sv
// -----------------------------------------------------------------------------
// preg_freelist
//   Free list for the 48-entry physical register file. Hands out up to two
//   free physical register numbers (prd) per cycle to rename, takes back up to
//   two released prds per cycle from commit, and rewinds speculative
//   allocations on a pipeline flush.
//
//   Storage is a circular buffer of FL_DEPTH entries addressed by three
//   pointers that each carry an extra wrap bit:
//     head        - next entry rename will receive (speculative)
//     commit_head - oldest entry not yet retired; flush rewinds head here
//     tail        - where released prds are written
//   free_count = tail - head (full-width pointer subtraction).
//
//   Optional feature: define FREELIST_CHECK_EN to track which prds are in the
//   list and raise a sticky error_o on misuse (double free, duplicate
//   same-cycle free, free of P0, overflow, commit_head overtaking head).
//   Without it error_o is tied low.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alloc_req_first_i/second_i       rename slots requesting a prd
//   alloc_ready_o                    >= 2 free entries; requests are accepted
//   alloc_prd_first_o/second_o       prds for the granted requests (peek)
//   free_valid_*_i, free_prd_*_i     prds released by commit slots 0/1
//   commit_alloc_first_i/second_i    retiring instruction had allocated a prd
//   flush_i                          squash all speculative allocations
//   free_count_o                     current number of free entries
//   error_o                          sticky misuse flag (FREELIST_CHECK_EN)
// -----------------------------------------------------------------------------
module preg_freelist #(
  parameter int REG_SIZE       = 48,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int ARCH_REGS      = 32,
  parameter int FL_DEPTH       = REG_SIZE - ARCH_REGS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_req_first_i,
  input  logic                      alloc_req_second_i,
  output logic                      alloc_ready_o,
  output logic [REG_SIZE_WIDTH-1:0] alloc_prd_first_o,
  output logic [REG_SIZE_WIDTH-1:0] alloc_prd_second_o,
  input  logic                      free_valid_first_i,
  input  logic [REG_SIZE_WIDTH-1:0] free_prd_first_i,
  input  logic                      free_valid_second_i,
  input  logic [REG_SIZE_WIDTH-1:0] free_prd_second_i,
  input  logic                      commit_alloc_first_i,
  input  logic                      commit_alloc_second_i,
  input  logic                      flush_i,
  output logic [REG_SIZE_WIDTH-1:0] free_count_o,
  output logic                      error_o
);

  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0]          ptr_t;
  typedef logic [REG_SIZE_WIDTH-1:0] prd_t;

  prd_t entries [FL_DEPTH];
  ptr_t head, commit_head, tail;
  ptr_t head_next, commit_head_next, tail_next;
  ptr_t head_plus1, tail_second, free_count;

  logic [1:0] n_alloc, n_free, n_commit;
  logic       free_first_ok, free_second_ok;

  // ---------------------------------------------------------------------------
  // Allocation side: zero-latency peek at head, compacted onto slot 0 when
  // only one request is raised.
  // ---------------------------------------------------------------------------
  assign free_count    = tail - head;
  assign alloc_ready_o = (free_count >= ptr_t'(2));
  assign free_count_o  = prd_t'(free_count);

  assign head_plus1         = head + ptr_t'(1);
  assign alloc_prd_first_o  = entries[head[IDX_W-1:0]];
  assign alloc_prd_second_o = (alloc_req_first_i && alloc_req_second_i)
                            ? entries[head_plus1[IDX_W-1:0]]
                            : entries[head[IDX_W-1:0]];

  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    n_alloc = 2'd0;
    if (alloc_ready_o && !flush_i) begin
      n_alloc = 2'(alloc_req_first_i) + 2'(alloc_req_second_i);
    end
  end

  // ---------------------------------------------------------------------------
  // Release side: P0 is hard-wired to zero in the regfile and must never
  // re-enter the list, so its frees are dropped here.
  // ---------------------------------------------------------------------------
  assign free_first_ok  = free_valid_first_i  && (free_prd_first_i  != '0);
  assign free_second_ok = free_valid_second_i && (free_prd_second_i != '0);
  assign n_free         = 2'(free_first_ok) + 2'(free_second_ok);
  assign tail_second    = tail + ptr_t'(free_first_ok);
  assign n_commit       = 2'(commit_alloc_first_i) + 2'(commit_alloc_second_i);

  assign commit_head_next = commit_head + ptr_t'(n_commit);
  assign tail_next        = tail + ptr_t'(n_free);
  // A flush rewinds to the committed point, including this cycle's retirements.
  assign head_next        = flush_i ? commit_head_next : head + ptr_t'(n_alloc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset because its reset contents are the
      // initial free list P(ARCH_REGS)..P(REG_SIZE-1), not don't-care data.
      for (int i = 0; i < FL_DEPTH; i++) begin
        entries[i] <= prd_t'(ARCH_REGS + i);
      end
      head        <= '0;
      commit_head <= '0;
      tail        <= ptr_t'(FL_DEPTH);
    end else begin
      if (free_first_ok) begin
        entries[tail[IDX_W-1:0]] <= free_prd_first_i;
      end
      if (free_second_ok) begin
        entries[tail_second[IDX_W-1:0]] <= free_prd_second_i;
      end
      head        <= head_next;
      commit_head <= commit_head_next;
      tail        <= tail_next;
    end
  end

`ifdef FREELIST_CHECK_EN
  // ---------------------------------------------------------------------------
  // Misuse checker: in_list mirrors which prds are currently held by the list
  // (including entries between commit_head and head that a flush would bring
  // back). Any violation sets a sticky error flag.
  // ---------------------------------------------------------------------------
  logic [REG_SIZE-1:0] in_list, in_list_next;
  logic                error_q, err_now;
  logic                err_dup, err_p0, err_present, err_overflow, err_passing;
  ptr_t                scan, restore_cnt, outstanding;

  assign restore_cnt = head - head_next;
  assign outstanding = head - commit_head;

  always_comb begin
    in_list_next = in_list;
    scan         = '0;
    if (flush_i) begin
      // Rewound entries [head_next, head) become free again.
      for (int i = 0; i < FL_DEPTH; i++) begin
        scan = head_next + ptr_t'(i);
        if (ptr_t'(i) < restore_cnt) begin
          in_list_next[entries[scan[IDX_W-1:0]]] = 1'b1;
        end
      end
    end else begin
      if (n_alloc != 2'd0) in_list_next[alloc_prd_first_o]  = 1'b0;
      if (n_alloc == 2'd2) in_list_next[alloc_prd_second_o] = 1'b0;
    end
    if (free_first_ok)  in_list_next[free_prd_first_i]  = 1'b1;
    if (free_second_ok) in_list_next[free_prd_second_i] = 1'b1;
  end

  assign err_dup      = free_valid_first_i && free_valid_second_i
                     && (free_prd_first_i == free_prd_second_i);
  assign err_p0       = (free_valid_first_i  && (free_prd_first_i  == '0))
                     || (free_valid_second_i && (free_prd_second_i == '0));
  assign err_present  = (free_first_ok  && in_list[free_prd_first_i])
                     || (free_second_ok && in_list[free_prd_second_i]);
  assign err_overflow = ((tail_next - head_next) > ptr_t'(FL_DEPTH));
  assign err_passing  = (ptr_t'(n_commit) > outstanding + ptr_t'(n_alloc));
  assign err_now      = err_dup || err_p0 || err_present || err_overflow || err_passing;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        in_list[i] <= (i >= ARCH_REGS);
      end
      error_q <= 1'b0;
    end else begin
      in_list <= in_list_next;
      error_q <= error_q | err_now;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: doc/preg_freelist.md
Name: preg_freelist

Overview:
- Allocator for the 48-entry physical register file.
- Hands out free physical register numbers (prd) to rename, up to two per cycle.
- Takes back released prds from commit, up to two per cycle.
- Restores the speculative allocation state on a pipeline flush.
- Sits between the rename stage and commit. Together with the regfile's P0-is-zero rule, it guarantees that P0 and architecturally mapped registers are never handed out twice.

Parameters:
- REG_SIZE, 48, number of physical registers.
- REG_SIZE_WIDTH, 6, width of a physical register index.
- ARCH_REGS, 32, physical registers P0..P31 mapped to x0..x31 at reset; never in the list at reset.
- FL_DEPTH, REG_SIZE-ARCH_REGS (16), free list capacity; must be a power of 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- alloc_req_first_i  input  1  rename slot 0 needs a prd
- alloc_req_second_i  input  1  rename slot 1 needs a prd
- alloc_ready_o  output  1  at least 2 free entries; allocation accepted this cycle
- alloc_prd_first_o  output  REG_SIZE_WIDTH  prd for first granted request
- alloc_prd_second_o  output  REG_SIZE_WIDTH  prd for second granted request
- free_valid_first_i  input  1  commit slot 0 releases a prd
- free_prd_first_i  input  REG_SIZE_WIDTH  prd released by slot 0
- free_valid_second_i  input  1  commit slot 1 releases a prd
- free_prd_second_i  input  REG_SIZE_WIDTH  prd released by slot 1
- commit_alloc_first_i  input  1  retiring slot 0 instruction had allocated a prd
- commit_alloc_second_i  input  1  retiring slot 1 instruction had allocated a prd
- flush_i  input  1  squash all speculative allocations
- free_count_o  output  REG_SIZE_WIDTH  current number of free entries
- error_o  output  1  sticky misuse flag (see Optional Feature)

Behaviour:
- Storage is a circular buffer of FL_DEPTH entries with a spec head, a commit head and a tail. Each pointer is log2(FL_DEPTH)+1 bits, including a wrap bit.
- Reset:
  - entry[i] = ARCH_REGS+i; head = commit_head = 0; tail = FL_DEPTH (wrap bit set, list full).
  - free_count_o = FL_DEPTH; error_o = 0.
- alloc_ready_o = (free_count >= 2), combinational from registered state.
- alloc_prd_first_o = entry[head]. alloc_prd_second_o is entry[head+1] if both requests are high, otherwise entry[head] (compaction).
- alloc_prd outputs are combinational, zero-latency peeks, valid whenever alloc_ready_o = 1.
- Accepted allocations = number of asserted requests when alloc_ready_o = 1. Head advances by that count at the clock edge.
- Requests while alloc_ready_o = 0 are ignored; rename must stall. There is no partial grant.
- Frees are written at tail, compacted: if only second valid, it goes to tail. Tail advances by the number of valid frees.
- A free of P0 is dropped: no write, no tail advance.
- A freed prd is not allocatable in the same cycle; it becomes visible next cycle.
- commit_head advances by commit_alloc_first_i + commit_alloc_second_i each cycle.
- flush_i:
  - head <= commit_head + this cycle's commit_alloc count.
  - Allocation requests in the flush cycle are discarded.
  - Frees and commit_alloc in the same cycle are still applied.
- free_count = tail - head (pointer subtraction including wrap bit). It is updated with +frees -allocs in the same cycle. Simultaneous alloc and free at the full/empty boundary is legal.
- Pointer wrap: the low bits index storage; the wrap bit toggles on crossing FL_DEPTH.
- rst mid-operation re-initialises everything to reset values regardless of other inputs.

Optional Feature:
- Macro FREELIST_CHECK_EN.
- Defined:
  - Maintains an REG_SIZE-bit in_list vector, set at reset for P(ARCH_REGS)..P(REG_SIZE-1).
  - error_o sets (sticky until rst) on any of:
    - free of a prd already in list;
    - two same-cycle frees of the same prd;
    - free of P0;
    - free when the list is full;
    - commit_head passing head.
- Undefined: no in_list vector; error_o tied 0; erroneous input behaviour is undefined apart from the P0 drop.

Test Plan:
- After reset: alloc_ready_o=1, free_count_o=16, alloc_prd_first_o=32, alloc_prd_second_o=33; both requests for one cycle -> next cycle first=34, count=14.
- Only alloc_req_second_i high from reset -> alloc_prd_second_o=32, next head prd=33, count=15.
- Allocate 14 (count=2), then both requests -> count=0, alloc_ready_o=0; further requests ignored. Free 40 and 41 -> count=2, alloc_prd_first_o=40 next cycle only.
- Allocate 4 (32..35), commit_alloc_first_i once, then flush_i -> head points at prd 33, count=15.
- Flush cycle with both alloc requests and free_valid_first_i prd=5 -> allocs discarded, 5 enqueued, count increments by 1.
- With FREELIST_CHECK_EN: free prd 32 twice without allocating it -> error_o=1 and stays 1 until rst; free prd 0 -> list unchanged.
